// File: rtl/bcd_to_bin_decoder.sv
// Sequential packed-BCD to binary decoder: one digit per clock, MSD first, valid/ready on both sides.
// Define BCD_SAT_EN to saturate bin_out to all-ones on overflow; by default it wraps modulo 2^BIN_W.
module bcd_to_bin_decoder #(
    parameter int NDIG  = 3,
    parameter int BIN_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*NDIG-1:0]  bcd_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIN_W-1:0]   bin_out,
    output logic               ovf,
    output logic               err,
    output logic [1:0]         state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, and out_valid/bin_out/ovf/err hold steady until out_ready.
    localparam int ACC_W = BIN_W + 4;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [4*NDIG-1:0]   shift_q;
    logic [BIN_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;
    logic                err_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [BIN_W-1:0]    bin_out_q;
    logic                ovf_out_q;
    logic                err_out_q;

    logic [3:0]          digit;
    logic [ACC_W-1:0]    acc_w;
    logic [BIN_W-1:0]    acc_d;
    logic                ovf_d;
    logic                err_d;
    logic [BIN_W-1:0]    result_d;

    always_comb begin
        digit = shift_q[4*NDIG-1 -: 4];
        acc_w = (ACC_W'(acc_q) << 3) + (ACC_W'(acc_q) << 1) + ACC_W'(digit);
        acc_d = acc_w[BIN_W-1:0];
        ovf_d = ovf_q | (acc_w[ACC_W-1:BIN_W] != 4'd0);
        err_d = err_q | (digit > 4'd9);
`ifdef BCD_SAT_EN
        result_d = ovf_q ? {BIN_W{1'b1}} : acc_q;
`else
        result_d = acc_q;
`endif
        // A bad digit makes the whole word meaningless, so the value is forced to zero.
        if (err_q) begin
            result_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bin_out_q   <= '0;
            ovf_out_q   <= 1'b0;
            err_out_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        shift_q    <= bcd_in;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        ovf_q      <= 1'b0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    shift_q <= shift_q << 4;
                    acc_q   <= acc_d;
                    ovf_q   <= ovf_d;
                    err_q   <= err_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NDIG - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle formats the result; outputs then freeze until taken.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        bin_out_q   <= result_d;
                        ovf_out_q   <= ovf_q & ~err_q;
                        err_out_q   <= err_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_out_q;
    assign ovf       = ovf_out_q;
    assign err       = err_out_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_bcd_to_bin_decoder.sv
// Directed bench for bcd_to_bin_decoder with a decimal reference model and an expected-result queue.
module tb_bcd_to_bin_decoder;

    localparam int NDIG  = 3;
    localparam int BIN_W = 8;
    localparam int RES_W = BIN_W + 2;

    logic               clk;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [4*NDIG-1:0]  bcd_in;
    logic               out_valid;
    logic               out_ready;
    logic [BIN_W-1:0]   bin_out;
    logic               ovf;
    logic               err;
    logic [1:0]         state_o;

    logic [RES_W-1:0]   exp_q[$];
    int                 n_cmp;
    int                 n_err;

    bcd_to_bin_decoder #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .ovf       (ovf),
        .err       (err),
        .state_o   (state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish within 500000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the word, then error / overflow / wrap-or-saturate.
    function automatic logic [RES_W-1:0] model(input logic [4*NDIG-1:0] b);
        int         v;
        logic       e;
        logic       o;
        logic [3:0] d;
        logic [BIN_W-1:0] r;
        v = 0;
        e = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            d = b[4*i +: 4];
            if (d > 4'd9) e = 1'b1;
            v = v * 10 + int'(d);
        end
        o = !e && (v >= (1 << BIN_W));
        if (e) r = '0;
`ifdef BCD_SAT_EN
        else if (o) r = '1;
`endif
        else r = BIN_W'(v % (1 << BIN_W));
        return {o, e, r};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Driver + scoreboard check for one word, with a consumer stall of 'stall' cycles.
    task automatic send_word(input logic [4*NDIG-1:0] b, input int stall);
        int               waited;
        int               lat;
        logic             rdy_seen;
        logic [RES_W-1:0] snap;
        logic [RES_W-1:0] exp;
        waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        bcd_in   = b;
        exp_q.push_back(model(b));
        tick();
        in_valid = 1'b0;
        bcd_in   = 12'($urandom);
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
        lat      = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
            if (in_ready) rdy_seen = 1'b1;
        end
        check("latency", 32'(lat), 32'(NDIG + 1));
        check("in_ready_low_busy", 32'(rdy_seen), 32'd0);
        snap = {ovf, err, bin_out};
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_result_stable", 32'({ovf, err, bin_out}), 32'(snap));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        exp = exp_q.pop_front();
        check($sformatf("result_%03h", b), 32'({ovf, err, bin_out}), 32'(exp));
        tick();
        out_ready = 1'b0;
        check("out_valid_cleared", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        check("state_idle", 32'(state_o), 32'd0);
    endtask

    initial begin
        logic [4*NDIG-1:0] w;
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_in    = '0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bin_out", 32'(bin_out), 32'd0);
        check("rst_ovf_err", 32'({ovf, err}), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        reset_n = 1'b1;
        tick();

        send_word(12'h255, 0);
        send_word(12'h256, 1);
        send_word(12'h999, 0);
        send_word(12'h1A3, 2);
        send_word(12'h042, 5);
        send_word(12'h000, 0);
        send_word(12'h9F0, 0);
        for (int k = 0; k < 8; k++) begin
            w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            send_word(w, $urandom_range(0, 3));
        end

        // Abort a conversion of 12'h128 after one CONV cycle; nothing may be presented for it.
        in_valid = 1'b1;
        bcd_in   = 12'h128;
        tick();
        in_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_state", 32'(state_o), 32'd0);
        check("abort_bin_out", 32'(bin_out), 32'd0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("no_stale_out_valid", 32'(out_valid), 32'd0);
        end
        send_word(12'h007, 0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
